// File: rtl/bar_level_conv_pkg.sv
// Shared widths, limits and FSM encoding for the FFT magnitude to bar-height converter.
package bar_level_conv_pkg;

   localparam int unsigned MAG_W    = 24;
   localparam int unsigned BAR_W    = 7;
   localparam int unsigned BAR_MAX  = (2 ** BAR_W) - 1;
   localparam int unsigned FRAC_W   = 3;
   localparam int unsigned OFFSET   = 64;
   localparam int unsigned N_BARS   = 800;
   localparam int unsigned ADDR_W   = 10;
   localparam int unsigned HOLD_CYC = 4;
   localparam int unsigned EXP_W    = $clog2(MAG_W);
   localparam int unsigned H_W      = EXP_W + FRAC_W + 2;
   localparam int unsigned HOLD_W   = $clog2(HOLD_CYC);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CONV = 3'd1,
      NEWF = 3'd2,
      GAP  = 3'd3,
      EMIT = 3'd4,
      HOLD = 3'd5
   } state_t;

endpackage

// File: rtl/bar_level_conv_lod.sv
// Leading-one detector: registered log2 exponent plus the FRAC_W bits just below the MSB.
module log2_lod
   import bar_level_conv_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MAG_W-1:0]  data,
   output logic [EXP_W-1:0]  expo,
   output logic [FRAC_W-1:0] mant,
   output logic              zero
);

   logic [EXP_W-1:0]  expo_c;
   logic [FRAC_W-1:0] mant_c;

   always_comb begin
      expo_c = '0;
      for (int i = 0; i < MAG_W; i++) begin
         if (data[i]) expo_c = EXP_W'(i);
      end
      // Align so the MSB lands just above the mantissa field; low bits zero-fill.
      if (expo_c >= EXP_W'(FRAC_W))
         mant_c = FRAC_W'(data >> (expo_c - EXP_W'(FRAC_W)));
      else
         mant_c = FRAC_W'(data << (EXP_W'(FRAC_W) - expo_c));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expo <= '0;
         mant <= '0;
         zero <= 1'b1;
      end else begin
         expo <= expo_c;
         mant <= mant_c;
         zero <= (data == '0);
      end
   end

endmodule

// File: rtl/bar_level_conv.sv
// Paces log-scaled bar heights into the peak-hold stage: one stable Bar per Start, NewFrame per frame.
module bar_level_conv
   import bar_level_conv_pkg::*;
(
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             MagValid,
   output logic             MagReady,
   input  logic [MAG_W-1:0] MagData,
   input  logic             MagLast,
   output logic [BAR_W-1:0] Bar,
   output logic             Start,
   output logic             NewFrame,
   output logic             OverrunErr
);

   state_t              state_q, state_d;
   logic                phase_q, phase_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [ADDR_W-1:0]   bar_cnt_q, bar_cnt_d;
   logic                first_q, first_d;
   logic                overrun_d, ready_d, start_d, newf_d;
   logic [MAG_W-1:0]    data_q;
   logic                last_q;
   logic                xfer;
   logic [EXP_W-1:0]    expo;
   logic [FRAC_W-1:0]   mant;
   logic                zero;
   logic signed [H_W-1:0] h_c;
   logic [BAR_W-1:0]    bar_c;

   assign xfer = MagValid & MagReady;

   log2_lod u_lod (
      .clk   (Clock),
      .rst_n (Reset_n),
      .data  (data_q),
      .expo  (expo),
      .mant  (mant),
      .zero  (zero)
   );

   // Noise-floor offset and clamp into the bar range.
   always_comb begin
      h_c = $signed(H_W'({expo, mant})) - $signed(H_W'(OFFSET));
      if (zero || h_c[H_W-1])
         bar_c = '0;
      else if (h_c > $signed(H_W'(BAR_MAX)))
         bar_c = BAR_W'(BAR_MAX);
      else
         bar_c = BAR_W'(h_c);
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = 1'b0;
      hold_d    = '0;
      bar_cnt_d = bar_cnt_q;
      first_d   = first_q;
      overrun_d = OverrunErr;
      case (state_q)
         IDLE: if (xfer) state_d = CONV;
         CONV: begin
            phase_d = 1'b1;
            if (phase_q) begin
               phase_d = 1'b0;
               state_d = first_q ? NEWF : EMIT;
               if (first_q) first_d = 1'b0;
            end
         end
         NEWF: state_d = GAP;
         GAP:  state_d = EMIT;
         EMIT: state_d = HOLD;
         HOLD: begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HOLD_W'(HOLD_CYC - 2)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Counter/frame bookkeeping is registered with Start so OverrunErr shows on that Start.
      if (state_d == EMIT) begin
         if (last_q || (bar_cnt_q == ADDR_W'(N_BARS - 1))) begin
            bar_cnt_d = '0;
            first_d   = 1'b1;
         end else begin
            bar_cnt_d = bar_cnt_q + 1'b1;
         end
         if (!last_q && (bar_cnt_q == ADDR_W'(N_BARS - 1))) overrun_d = 1'b1;
      end
      ready_d = (state_d == IDLE);
      start_d = (state_d == EMIT);
      newf_d  = (state_d == NEWF);
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         phase_q    <= 1'b0;
         hold_q     <= '0;
         bar_cnt_q  <= '0;
         first_q    <= 1'b1;
         data_q     <= '0;
         last_q     <= 1'b0;
         Bar        <= '0;
         Start      <= 1'b0;
         NewFrame   <= 1'b0;
         MagReady   <= 1'b0;
         OverrunErr <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         hold_q     <= hold_d;
         bar_cnt_q  <= bar_cnt_d;
         first_q    <= first_d;
         Start      <= start_d;
         NewFrame   <= newf_d;
         MagReady   <= ready_d;
         OverrunErr <= overrun_d;
         if (xfer) begin
            data_q <= MagData;
            last_q <= MagLast;
         end
         if (state_q == CONV && phase_q) Bar <= bar_c;
      end
   end

endmodule
